// File: rtl/demux1xn_stream_pkg.sv
// demux_pkg: shared FSM state type and counter widths for demux1xn_stream
package demux_pkg;
  typedef enum logic [1:0] {IDLE, IN_PKT, DROP} demux_state_e;
  localparam int DROP_W = 8;
  localparam logic [DROP_W-1:0] DROP_MAX = 8'd255;
  localparam int STAT_W = 16;
endpackage

// File: rtl/demux1xn_stream_if.sv
// demux1xn_stream_if: one input stream fanned out to N_OUT output streams
interface demux1xn_stream_if #(
  parameter int WIDTH = 8,
  parameter int N_OUT = 4
);
  localparam int SEL_W = $clog2(N_OUT);
  logic [WIDTH-1:0]            in_data;
  logic [SEL_W-1:0]            in_sel;
  logic                        in_last;
  logic                        in_valid;
  logic                        in_ready;
  logic [N_OUT-1:0][WIDTH-1:0] out_data;
  logic [N_OUT-1:0]            out_last;
  logic [N_OUT-1:0]            out_valid;
  logic [N_OUT-1:0]            out_ready;
  modport master (
    output in_data, in_sel, in_last, in_valid, out_ready,
    input  in_ready, out_data, out_last, out_valid
  );
  modport slave (
    input  in_data, in_sel, in_last, in_valid, out_ready,
    output in_ready, out_data, out_last, out_valid
  );
endinterface

// File: rtl/demux1xn_stream_slot.sv
// stream_slot: one-entry valid/ready holding register for data and last
module stream_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last
);
  logic             valid_q, valid_d, last_q, last_d;
  logic [WIDTH-1:0] data_q, data_d;
  // a load always wins; otherwise the slot empties once its beat is taken
  always_comb begin
    valid_d = load | (valid_q & ~out_ready);
    data_d  = load ? in_data : data_q;
    last_d  = load ? in_last : last_q;
  end
  // slot register
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_last  = last_q;
endmodule

// File: rtl/demux1xn_stream.sv
// demux1xn_stream: registered 1-to-N packet demux; DEMUX1XN_STATS_EN adds per-output beat counters
module demux1xn_stream
  import demux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N_OUT = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  demux1xn_stream_if.slave                s,
  output logic [DROP_W-1:0]               drop_cnt
`ifdef DEMUX1XN_STATS_EN
  ,
  input  logic                            clr_stats,
  output logic [N_OUT-1:0][STAT_W-1:0]    beat_cnt
`endif
);
  localparam int SEL_W = $clog2(N_OUT);
  demux_state_e                state_q, state_d;
  logic [SEL_W-1:0]            d, lock_q, lock_d;
  logic [DROP_W-1:0]           drop_q, drop_d;
  logic [N_OUT-1:0]            sel_oh, load, ov, ol;
  logic [N_OUT-1:0][WIDTH-1:0] od;
  logic                        oor, acc;
  // steer: destination is in_sel at packet start, the locked index afterwards; out-of-range sinks
  always_comb begin
    d = state_q == IDLE ? s.in_sel : lock_q;
    for (int i = 0; i < N_OUT; i++) sel_oh[i] = d == SEL_W'(i);
    oor = ~|sel_oh;
    s.in_ready = state_q == DROP || oor || |(sel_oh & (~ov | s.out_ready));
    acc = s.in_valid && s.in_ready;
    load = (acc && state_q != DROP) ? sel_oh : '0;
  end
  // packet framing: lock destination on first beat, count out-of-range packets once
  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    drop_d  = drop_q;
    if (acc)
      case (state_q)
        IDLE: begin
          if (oor) drop_d = drop_q == DROP_MAX ? drop_q : drop_q + 1'b1;
          if (!s.in_last) begin
            state_d = oor ? DROP : IN_PKT;
            lock_d  = s.in_sel;
          end
        end
        default: state_d = s.in_last ? IDLE : state_q;
      endcase
  end
  // FSM, lock and drop counter registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      lock_q  <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
      drop_q  <= drop_d;
    end
  assign drop_cnt = drop_q;
  for (genvar i = 0; i < N_OUT; i++) begin : g_slot
    stream_slot #(.WIDTH(WIDTH)) u_slot (
      .clk       (clk),
      .rst       (rst),
      .load      (load[i]),
      .in_data   (s.in_data),
      .in_last   (s.in_last),
      .out_ready (s.out_ready[i]),
      .out_valid (ov[i]),
      .out_data  (od[i]),
      .out_last  (ol[i])
    );
  end
  assign s.out_valid = ov;
  assign s.out_data  = od;
  assign s.out_last  = ol;
`ifdef DEMUX1XN_STATS_EN
  logic [N_OUT-1:0][STAT_W-1:0] cnt_q, cnt_d;
  // completed output transfers, clear beats a same-cycle increment
  always_comb
    for (int i = 0; i < N_OUT; i++)
      cnt_d[i] = clr_stats ? '0 : cnt_q[i] + STAT_W'(ov[i] & s.out_ready[i]);
  // stats registers
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign beat_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_demux1xn_stream.sv
// tb_demux1xn_stream: scoreboard bench for N_OUT=4 and N_OUT=3 instances
module tb_demux1xn_stream;
  import demux_pkg::*;
  logic clk = 0, rst = 0;
  logic [7:0] dc4, dc3;
`ifdef DEMUX1XN_STATS_EN
  logic clr4 = 0, clr3 = 0;
  logic [3:0][15:0] bc4;
  logic [2:0][15:0] bc3;
`endif
  demux1xn_stream_if #(.WIDTH(8), .N_OUT(4)) i4 ();
  demux1xn_stream_if #(.WIDTH(8), .N_OUT(3)) i3 ();
  demux1xn_stream #(.WIDTH(8), .N_OUT(4)) dut4 (
    .clk(clk), .rst(rst), .s(i4), .drop_cnt(dc4)
`ifdef DEMUX1XN_STATS_EN
    , .clr_stats(clr4), .beat_cnt(bc4)
`endif
  );
  demux1xn_stream #(.WIDTH(8), .N_OUT(3)) dut3 (
    .clk(clk), .rst(rst), .s(i3), .drop_cnt(dc3)
`ifdef DEMUX1XN_STATS_EN
    , .clr_stats(clr3), .beat_cnt(bc3)
`endif
  );
  always #5 clk = ~clk;
  int n_chk = 0, n_fail = 0;
  logic [8:0] sbq [2][4][$];
  logic       busy [2];
  logic [1:0] dest [2];
  logic [7:0] exp_drop [2];
  int         nout [2] = '{4, 3};
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic pop(int u, int i, logic [8:0] got);
    if (sbq[u][i].size() == 0) chk($sformatf("spurious u%0d o%0d", u, i), sbq[u][i].size(), 1);
    else chk($sformatf("data u%0d o%0d", u, i), got, sbq[u][i].pop_front());
  endtask
  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send(int u, logic [7:0] dat, logic [1:0] sel, logic last);
    int t = 0;
    logic rdy;
    if (u == 0) begin
      i4.in_data = dat; i4.in_sel = sel; i4.in_last = last; i4.in_valid = 1;
    end else begin
      i3.in_data = dat; i3.in_sel = sel; i3.in_last = last; i3.in_valid = 1;
    end
    do begin
      @(negedge clk);
      rdy = u == 0 ? i4.in_ready : i3.in_ready;
      t++;
    end while (!rdy && t < 50);
    if (!rdy) chk("in_ready_timeout", {31'b0, rdy}, 1);
    else begin
      if (!busy[u]) begin
        dest[u] = sel;
        if (int'(sel) >= nout[u]) exp_drop[u] = exp_drop[u] == 8'd255 ? 8'd255 : exp_drop[u] + 8'd1;
      end
      if (int'(dest[u]) < nout[u]) sbq[u][dest[u]].push_back({last, dat});
      busy[u] = !last;
    end
    @(posedge clk);
    #1;
    if (u == 0) i4.in_valid = 0; else i3.in_valid = 0;
  endtask
  always @(negedge clk)
    if (!rst) begin
      for (int i = 0; i < 4; i++)
        if (i4.out_valid[i] && i4.out_ready[i]) pop(0, i, {i4.out_last[i], i4.out_data[i]});
      for (int i = 0; i < 3; i++)
        if (i3.out_valid[i] && i3.out_ready[i]) pop(1, i, {i3.out_last[i], i3.out_data[i]});
    end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    i4.in_data = 0; i4.in_sel = 0; i4.in_last = 0; i4.in_valid = 0; i4.out_ready = 4'hF;
    i3.in_data = 0; i3.in_sel = 0; i3.in_last = 0; i3.in_valid = 0; i3.out_ready = 3'h7;
    busy = '{0, 0}; dest = '{0, 0}; exp_drop = '{0, 0};
    #1 rst = 1;
    cyc(2);
    chk("rst_valid", {28'b0, i4.out_valid}, 0);
    chk("rst_data", i4.out_data, 0);
    chk("rst_last", {28'b0, i4.out_last}, 0);
    chk("rst_drop", {24'b0, dc3}, 0);
    chk("rst_in_ready", {31'b0, i4.in_ready}, 1);
    rst = 0;
    cyc(1);
    send(0, 8'hA5, 2, 1);
    @(negedge clk);
    chk("t1_valid", {28'b0, i4.out_valid}, 4'b0100);
    chk("t1_data", {24'b0, i4.out_data[2]}, 8'hA5);
    chk("t1_last", {31'b0, i4.out_last[2]}, 1);
    chk("t1_idle", dut4.state_q, IDLE);
    cyc(1);
    send(0, 8'h11, 1, 0);
    chk("t2_locked", dut4.state_q, IN_PKT);
    send(0, 8'h22, 3, 0);
    send(0, 8'h33, 3, 1);
    send(0, 8'h3C, 3, 1);
    cyc(3);
    chk("t2_drained", sbq[0][1].size(), 0);
    i4.out_ready[0] = 0;
    send(0, 8'h01, 0, 1);
    i4.in_data = 8'h02; i4.in_sel = 0; i4.in_last = 1; i4.in_valid = 1;
    @(negedge clk);
    chk("t3_held_valid", {31'b0, i4.out_valid[0]}, 1);
    chk("t3_held_data", {24'b0, i4.out_data[0]}, 8'h01);
    chk("t3_stall", {31'b0, i4.in_ready}, 0);
    cyc(2);
    i4.out_ready[0] = 1;
    send(0, 8'h02, 0, 1);
    cyc(3);
    chk("t3_drained", sbq[0][0].size(), 0);
    i4.out_ready = 4'h0;
    send(0, 8'hB1, 0, 0);
    #2 rst = 1;
    #1;
    chk("rst_mid_valid", {28'b0, i4.out_valid}, 0);
    chk("rst_mid_idle", dut4.state_q, IDLE);
    cyc(1);
    rst = 0;
    for (int u = 0; u < 2; u++) for (int i = 0; i < 4; i++) sbq[u][i].delete();
    busy = '{0, 0}; exp_drop = '{0, 0};
    chk("rst_mid_drop", {24'b0, dc4}, 0);
    i4.out_ready = 4'hF;
    send(0, 8'hC7, 0, 1);
    @(negedge clk);
    chk("rst_route_valid", {28'b0, i4.out_valid}, 4'b0001);
    chk("rst_route_data", {24'b0, i4.out_data[0]}, 8'hC7);
    cyc(2);
    send(1, 8'hD0, 3, 0);
    chk("drop_state", dut3.state_q, DROP);
    send(1, 8'hD1, 3, 1);
    @(negedge clk);
    chk("drop_idle_out", {29'b0, i3.out_valid}, 0);
    chk("drop_cnt1", {24'b0, dc3}, {24'b0, exp_drop[1]});
    chk("drop_cnt1_abs", {24'b0, dc3}, 1);
    cyc(1);
    send(1, 8'hE2, 2, 0);
    send(1, 8'hE3, 0, 1);
    cyc(3);
    for (int k = 0; k < 300; k++) begin
      send(1, 8'(k), 3, k[0]);
      if (!k[0]) send(1, 8'(k + 1), 1, 1);
    end
    cyc(2);
    chk("drop_sat_model", {24'b0, dc3}, {24'b0, exp_drop[1]});
    chk("drop_sat", {24'b0, dc3}, 255);
    chk("drop_sat_out", {29'b0, i3.out_valid}, 0);
`ifdef DEMUX1XN_STATS_EN
    clr4 = 1;
    cyc(1);
    clr4 = 0;
    for (int k = 0; k < 5; k++) send(0, 8'h60 + 8'(k), 2, 1);
    cyc(2);
    chk("stats5", {16'b0, bc4[2]}, 5);
    chk("stats_other", {16'b0, bc4[0]}, 0);
    clr4 = 1;
    send(0, 8'h66, 2, 1);
    cyc(1);
    clr4 = 0;
    @(negedge clk);
    chk("stats_clr", {16'b0, bc4[2]}, 0);
    cyc(1);
    send(0, 8'h67, 2, 1);
    cyc(2);
    chk("stats_after", {16'b0, bc4[2]}, 1);
`endif
    cyc(5);
    for (int u = 0; u < 2; u++)
      for (int i = 0; i < nout[u]; i++) chk($sformatf("sb_left u%0d o%0d", u, i), sbq[u][i].size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
